// File: rtl/output_pipeline.sv
// Equalizer output stage: re-reads image words from m1, maps each pixel through the m3 LUT, and writes packed words to m4.
// Optional `OUTPUT_PIPELINE_TAG_CHECK_EN zeroes any lane whose LUT entry lacks the valid tag.
module output_pipeline #(
  parameter int          NUM_WORDS = 4,
  parameter logic [15:0] TAG       = 16'hAAAA
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         lutBaseOffset,
  input  logic [127:0] m1ReadVal,
  input  logic [127:0] m3ReadVal,
  output logic [15:0]  m1ReadAddr,
  output logic [15:0]  m3ReadAddr,
  output logic [15:0]  m4WriteAddr,
  output logic [127:0] m4WriteVal,
  output logic         m4WE,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, RD_IMG, LATCH, LOOKUP, WAIT_LAST, WRITE, DONE
  } state_t;

  localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);

  state_t       state, state_nxt;
  logic [15:0]  word_idx;
  logic [3:0]   lane;
  logic [3:0]   prev_lane;
  logic [127:0] img_word;
  logic [127:0] pack;
  logic [7:0]   mapped;

`ifdef OUTPUT_PIPELINE_TAG_CHECK_EN
  assign mapped = (m3ReadVal[31:16] == TAG) ? m3ReadVal[7:0] : 8'h00;
  logic unused_m3_bits;
  assign unused_m3_bits = ^{m3ReadVal[127:32], m3ReadVal[15:8]};
`else
  assign mapped = m3ReadVal[7:0];
  logic unused_m3_bits;
  assign unused_m3_bits = ^{m3ReadVal[127:16], m3ReadVal[15:8], TAG};
`endif

  // The LUT result arriving now belongs to the lane addressed last cycle.
  assign prev_lane = lane - 4'd1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_idx <= '0;
      lane     <= '0;
      img_word <= '0;
      pack     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: word_idx <= '0;
        LATCH: begin
          img_word <= m1ReadVal;
          lane     <= '0;
        end
        LOOKUP: begin
          lane <= lane + 4'd1;
          if (lane != 4'd0) pack[{prev_lane, 3'b000} +: 8] <= mapped;
        end
        WAIT_LAST: pack[127:120] <= mapped;
        WRITE: if (word_idx != LAST_WORD) word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    m1ReadAddr  = '0;
    m3ReadAddr  = '0;
    m4WriteAddr = '0;
    m4WriteVal  = '0;
    m4WE        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = RD_IMG;
      RD_IMG: begin
        m1ReadAddr = word_idx;
        state_nxt  = LATCH;
      end
      LATCH:  state_nxt = LOOKUP;
      LOOKUP: begin
        m3ReadAddr = {7'b0, lutBaseOffset, img_word[{lane, 3'b000} +: 8]};
        if (lane == 4'd15) state_nxt = WAIT_LAST;
      end
      WAIT_LAST: state_nxt = WRITE;
      WRITE: begin
        m4WE        = 1'b1;
        m4WriteAddr = word_idx;
        m4WriteVal  = pack;
        state_nxt   = (word_idx == LAST_WORD) ? DONE : RD_IMG;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
